vga_timing_gen: RTL and testbench

- Pixel-timing generator that sits directly upstream of the VGA demo renderer in the top-level tile.
- Produces the raster position (hpos/vpos), sync pulses, the display-enable window, and frame/line strobes.
- The renderer consumes these to compute the RGB for the current pixel and to drive the uo_out sync bits.
- Default timing is 640x480@60 with a 25.175 MHz pixel clock; a clock-enable input allows operation from a faster system clock.

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, display-enable
// and line/frame strobes, all aligned to the hpos/vpos they describe.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_display_on;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_cnt;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_hpos_nxt;
    logic [9:0] w_vpos_nxt;
    logic [10:0] w_hx;
    logic [10:0] w_vx;
    logic       w_hsync_nxt;
    logic       w_vsync_nxt;
    logic       w_display_nxt;

    // Outputs are decoded from the next counter values so they register alongside hpos/vpos.
    always_comb begin
        w_h_wrap   = (r_hpos == H_LAST);
        w_v_wrap   = (r_vpos == V_LAST);
        w_hpos_nxt = w_h_wrap ? '0 : r_hpos + 10'd1;
        w_vpos_nxt = r_vpos;
        if (w_h_wrap) begin
            w_vpos_nxt = w_v_wrap ? '0 : r_vpos + 10'd1;
        end
        w_hx          = {1'b0, w_hpos_nxt};
        w_vx          = {1'b0, w_vpos_nxt};
        w_hsync_nxt   = ((w_hx >= HS_BEGIN) && (w_hx < HS_END)) ? SYNC_POL : ~SYNC_POL;
        w_vsync_nxt   = ((w_vx >= VS_BEGIN) && (w_vx < VS_END)) ? SYNC_POL : ~SYNC_POL;
        w_display_nxt = (w_hx < H_ACT) && (w_vx < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else if (pix_en) begin
            r_hpos        <= w_hpos_nxt;
            r_vpos        <= w_vpos_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_display_on  <= w_display_nxt;
            r_line_start  <= (w_hpos_nxt == '0);
            r_frame_start <= (w_hpos_nxt == '0) && (w_vpos_nxt == '0);
            if (w_h_wrap && w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a tiny-timing instance
// (inverted sync polarity) checked every cycle against a position-from-pixel-count model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, en0 = 1'b1, rst1 = 1'b1, en1 = 1'b1;
    logic [9:0] hpos0, vpos0, hpos1, vpos1;
    logic       hsync0, vsync0, disp0, ls0, fs0;
    logic       hsync1, vsync1, disp1, ls1, fs1;
    logic [7:0] fc0, fc1;

    int     errors = 0;
    int     checks = 0;
    longint n0 = 0;
    longint n1 = 0;

    vga_timing_gen dut0 (
        .clk(clk), .reset(rst0), .pix_en(en0),
        .hpos(hpos0), .vpos(vpos0), .hsync(hsync0), .vsync(vsync0),
        .display_on(disp0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .reset(rst1), .pix_en(en1),
        .hpos(hpos1), .vpos(vpos1), .hsync(hsync1), .vsync(vsync1),
        .display_on(disp1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    // Expected outputs given the number of enabled pixels since reset (0 = still in reset state).
    function automatic logic [32:0] model(input longint n, input int ha, input int hf,
                                          input int hs, input int hb, input int va,
                                          input int vf, input int vs, input int vb,
                                          input logic pol);
        longint ht, vt, p, h, v, fc;
        logic [32:0] r;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        r  = '0;
        if (n == 0) begin
            r[12] = ~pol;
            r[11] = ~pol;
            return r;
        end
        p  = n % (ht * vt);
        h  = p % ht;
        v  = p / ht;
        fc = (n / (ht * vt)) % 256;
        r[32:23] = 10'(h);
        r[22:13] = 10'(v);
        r[12]    = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
        r[11]    = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
        r[10]    = (h < ha) && (v < va);
        r[9]     = (h == 0);
        r[8]     = (p == 0);
        r[7:0]   = 8'(fc);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string p, input logic [32:0] obs, input logic [32:0] exp);
        check({p, "_hpos"},        32'(obs[32:23]), 32'(exp[32:23]));
        check({p, "_vpos"},        32'(obs[22:13]), 32'(exp[22:13]));
        check({p, "_hsync"},       32'(obs[12]),    32'(exp[12]));
        check({p, "_vsync"},       32'(obs[11]),    32'(exp[11]));
        check({p, "_display_on"},  32'(obs[10]),    32'(exp[10]));
        check({p, "_line_start"},  32'(obs[9]),     32'(exp[9]));
        check({p, "_frame_start"}, 32'(obs[8]),     32'(exp[8]));
        check({p, "_frame_cnt"},   32'(obs[7:0]),   32'(exp[7:0]));
    endtask

    task automatic step(input logic r0, input logic e0, input logic r1, input logic e1);
        @(negedge clk);
        rst0 = r0; en0 = e0; rst1 = r1; en1 = e1;
        @(posedge clk);
        n0 = r0 ? 0 : (e0 ? n0 + 1 : n0);
        n1 = r1 ? 0 : (e1 ? n1 + 1 : n1);
        #1;
        cmp("d0", {hpos0, vpos0, hsync0, vsync0, disp0, ls0, fs0, fc0},
            model(n0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        cmp("d1", {hpos1, vpos1, hsync1, vsync1, disp1, ls1, fs1, fc1},
            model(n1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1));
    endtask

    function automatic logic rnd_en();
        return $urandom_range(0, 3) != 0;
    endfunction

    function automatic logic rnd_rst();
        return $urandom_range(0, 299) == 0;
    endfunction

    initial begin
        int         hs_cnt;
        int         ls_cnt;
        logic [9:0] h_before;
        logic [9:0] v_before;
        longint     target;
        int         budget;
        int         wrap_seen;

        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b1);

        // one full default line: sync width and wrap into line 1
        hs_cnt = 0;
        repeat (800) begin
            step(1'b0, 1'b1, rnd_rst(), rnd_en());
            if (hsync0 == 1'b0) hs_cnt++;
        end
        check("d0_hsync_width", 32'(hs_cnt), 32'd96);
        check("d0_wrap_hpos", 32'(hpos0), 32'd0);
        check("d0_wrap_vpos", 32'(vpos0), 32'd1);
        check("d0_wrap_line_start", 32'(ls0), 32'd1);

        repeat (300) step(1'b0, 1'b1, rnd_rst(), rnd_en());

        // pix_en toggling: 800 enabled pixels over 1600 clocks
        h_before = hpos0;
        v_before = vpos0;
        ls_cnt   = 0;
        for (int i = 0; i < 1600; i++) begin
            step(1'b0, (i % 2) == 0, rnd_rst(), rnd_en());
            if (ls0) ls_cnt++;
        end
        check("d0_gate_hpos", 32'(hpos0), 32'(h_before));
        check("d0_gate_vpos", 32'(vpos0), 32'(v_before) + 32'd1);
        check("d0_gate_ls_cycles", 32'(ls_cnt), 32'd2);

        // mid-line reset then resume
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("d0_midreset_hpos", 32'(hpos0), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("d0_resume_hpos", 32'(hpos0), 32'd1);

        // tiny timing: run past 256 frames so frame_cnt wraps 255->0
        step(1'b0, 1'b1, 1'b1, 1'b1);
        target    = 257 * 84;
        budget    = 40000;
        wrap_seen = 0;
        while (n1 < target && budget > 0) begin
            step(1'b0, 1'b1, 1'b0, rnd_en());
            if (n1 == 256 * 84 && fs1 && fc1 == 8'd0) wrap_seen++;
            budget--;
        end
        check("d1_budget", 32'(n1 >= target), 32'd1);
        check("d1_wrap_seen", 32'(wrap_seen > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
